mem_responder: RTL and testbench

- Backing-memory responder on the memory side of the data-cache miss/writeback interface.
- Accepts one-cycle `mem_write` and `mem_fetch` request pulses from the cache.
- Holds `wait_signal` high while it emulates a fixed-latency main memory.
- Returns fetched words as four bytes with a one-cycle valid strobe. A writeback issued together with a fill is performed first.

---
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_responder.sv | 132 +++++++++++++
 tb/tb_mem_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bundle for the backing-memory responder.
// The cache drives requests as master; the responder answers as slave.
interface mem_responder_if;
    logic             mem_fetch;
    logic [31:0]      fetch_mem_addr;
    logic             mem_write;
    logic [31:0]      write_mem_addr;
    logic [3:0][7:0]  write_word_in;
    logic             wait_signal;
    logic [3:0][7:0]  fetch_word_out;
    logic             fetch_valid;

    modport master (
        output mem_fetch,
        output fetch_mem_addr,
        output mem_write,
        output write_mem_addr,
        output write_word_in,
        input  wait_signal,
        input  fetch_word_out,
        input  fetch_valid
    );

    modport slave (
        input  mem_fetch,
        input  fetch_mem_addr,
        input  mem_write,
        input  write_mem_addr,
        input  write_word_in,
        output wait_signal,
        output fetch_word_out,
        output fetch_valid
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency backing memory behind the data-cache miss/writeback port.
// A combined request performs the writeback before the fill.
module mem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FETCH = 2'd2
    } state_t;

    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam logic [7:0] RELOAD = 8'(LATENCY - 1);

    logic [31:0] mem_array [DEPTH];

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   wait_q, wait_d;
    logic                   valid_q, valid_d;
    logic [31:0]            word_q, word_d;
    logic [ADDR_BITS-1:0]   fetch_idx_q, fetch_idx_d;
    logic [ADDR_BITS-1:0]   write_idx_q, write_idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   fetch_flag_q, fetch_flag_d;
    logic                   mem_we;

    // Only the word-index bits of each address select a location.
    logic [ADDR_BITS-1:0]   req_fetch_idx;
    logic [ADDR_BITS-1:0]   req_write_idx;
    logic                   unused_addr_bits;

    assign req_fetch_idx    = bus.fetch_mem_addr[ADDR_BITS+1:2];
    assign req_write_idx    = bus.write_mem_addr[ADDR_BITS+1:2];
    assign unused_addr_bits = ^{bus.fetch_mem_addr, bus.write_mem_addr};

    // Next-state logic: capture in IDLE, count down, act when counter hits 0.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_d      = 1'b0;
        word_d       = word_q;
        fetch_idx_d  = fetch_idx_q;
        write_idx_d  = write_idx_q;
        wdata_d      = wdata_q;
        fetch_flag_d = fetch_flag_q;
        mem_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.mem_write || bus.mem_fetch) begin
                    fetch_idx_d  = req_fetch_idx;
                    write_idx_d  = req_write_idx;
                    wdata_d      = bus.write_word_in;
                    fetch_flag_d = bus.mem_fetch;
                    cnt_d        = RELOAD;
                    state_d      = bus.mem_write ? WRITE : FETCH;
                end
            end
            WRITE: begin
                if (cnt_q == 8'd0) begin
                    mem_we = 1'b1;
                    if (fetch_flag_q) begin
                        cnt_d   = RELOAD;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            FETCH: begin
                if (cnt_q == 8'd0) begin
                    word_d  = mem_array[fetch_idx_q];
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wait_d = (state_d != IDLE);
    end

    // FSM state, counter, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            wait_q       <= 1'b0;
            valid_q      <= 1'b0;
            word_q       <= 32'd0;
            fetch_idx_q  <= '0;
            write_idx_q  <= '0;
            wdata_q      <= 32'd0;
            fetch_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            valid_q      <= valid_d;
            word_q       <= word_d;
            fetch_idx_q  <= fetch_idx_d;
            write_idx_q  <= write_idx_d;
            wdata_q      <= wdata_d;
            fetch_flag_q <= fetch_flag_d;
        end
    end

    // Storage array; reset never clears it but does block a pending write.
    always_ff @(posedge clk) begin
        if (!rst_b && mem_we) begin
            mem_array[write_idx_q] <= wdata_q;
        end
    end

    assign bus.wait_signal    = wait_q;
    assign bus.fetch_valid    = valid_q;
    assign bus.fetch_word_out = word_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected fill words,
// a negedge monitor pops and compares on every fetch_valid strobe.
module tb_mem_responder;

    logic clk;
    logic rst_b;
    int   errors;
    int   checks;
    logic [31:0] exp_q [$];

    mem_responder_if bus_if ();

    mem_responder #(
        .ADDR_BITS (12),
        .LATENCY   (4)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding fill.
    always @(negedge clk) begin
        if (bus_if.fetch_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got word %h expected no strobe",
                         bus_if.fetch_word_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus_if.fetch_word_out !== e || bus_if.wait_signal !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_word: got %h wait=%b expected %h wait=0",
                             bus_if.fetch_word_out, bus_if.wait_signal, e);
                end
            end
        end
    end

    task automatic clear_inputs();
        bus_if.mem_fetch      = 1'b0;
        bus_if.mem_write      = 1'b0;
        bus_if.fetch_mem_addr = 32'd0;
        bus_if.write_mem_addr = 32'd0;
        bus_if.write_word_in  = 32'd0;
    endtask

    task automatic count_wait(output int n);
        n = 0;
        while (bus_if.wait_signal === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the first negedge with wait_signal low.
    task automatic do_req(input string name, input logic w,
                          input logic [31:0] waddr, input logic [31:0] wdata,
                          input logic f, input logic [31:0] faddr,
                          input int exp_wait);
        int n;
        bus_if.mem_write      = w;
        bus_if.write_mem_addr = waddr;
        bus_if.write_word_in  = wdata;
        bus_if.mem_fetch      = f;
        bus_if.fetch_mem_addr = faddr;
        @(negedge clk);
        clear_inputs();
        count_wait(n);
        chk(name, 32'(n), 32'(exp_wait));
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        clear_inputs();
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_wait", 32'(bus_if.wait_signal), 32'd0);
            chk("reset_valid", 32'(bus_if.fetch_valid), 32'd0);
            chk("reset_word", bus_if.fetch_word_out, 32'd0);
        end

        do_req("wr10_wait", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 4);
        chk("word_hold_after_write", bus_if.fetch_word_out, 32'd0);

        exp_q.push_back(32'hDEADBEEF);
        do_req("rd10_wait", 1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 4);

        exp_q.push_back(32'h11223344);
        do_req("combo20_wait", 1'b1, 32'h20, 32'h11223344, 1'b1, 32'h20, 8);

        do_req("alias_wr_wait", 1'b1, 32'h4004, 32'hCAFEF00D, 1'b0, 32'h0, 4);
        exp_q.push_back(32'hCAFEF00D);
        do_req("alias_rd_wait", 1'b0, 32'h0, 32'h0, 1'b1, 32'h7, 4);
        @(negedge clk);
        chk("word_hold", bus_if.fetch_word_out, 32'hCAFEF00D);

        // Fetch pulse during a write must be dropped.
        bus_if.mem_write      = 1'b1;
        bus_if.write_mem_addr = 32'h30;
        bus_if.write_word_in  = 32'h0BADF00D;
        @(negedge clk);
        clear_inputs();
        chk("busy_wait_start", 32'(bus_if.wait_signal), 32'd1);
        bus_if.mem_fetch      = 1'b1;
        bus_if.fetch_mem_addr = 32'h10;
        @(negedge clk);
        clear_inputs();
        count_wait(n);
        chk("busy_wait_total", 32'(n + 1), 32'd4);
        repeat (6) @(negedge clk);
        exp_q.push_back(32'h0BADF00D);
        do_req("rd30_wait", 1'b0, 32'h0, 32'h0, 1'b1, 32'h30, 4);

        // Reset in the second wait cycle of a fetch.
        bus_if.mem_fetch      = 1'b1;
        bus_if.fetch_mem_addr = 32'h10;
        @(negedge clk);
        clear_inputs();
        chk("rst_mid_wait1", 32'(bus_if.wait_signal), 32'd1);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst_mid_wait", 32'(bus_if.wait_signal), 32'd0);
        chk("rst_mid_valid", 32'(bus_if.fetch_valid), 32'd0);
        chk("rst_mid_word", bus_if.fetch_word_out, 32'd0);
        rst_b = 1'b0;
        repeat (8) @(negedge clk);

        exp_q.push_back(32'h11223344);
        do_req("post_rst_rd20", 1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 4);
        exp_q.push_back(32'hDEADBEEF);
        do_req("post_rst_rd10", 1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 4);

        repeat (8) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
